// File: rtl/bist_controller_param.sv
// Parametrised LFSR/MISR BIST controller: drives pseudo-random patterns into a CUT,
// compacts the delayed responses and checks the final signature against GOLDEN.
module bist_controller_param #(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] POLY       = 8'hB8,
   parameter logic [WIDTH-1:0] SEED       = 8'h01,
   parameter int unsigned      N_PATTERNS = 200,
   parameter int unsigned      CUT_LAT    = 0,
   parameter logic [WIDTH-1:0] GOLDEN     = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] cut_resp,
   output logic [WIDTH-1:0] pattern_out,
   output logic             pattern_valid,
   output logic             running,
   output logic             bist_end,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam int unsigned CW        = $clog2(N_PATTERNS + 1);
   localparam int unsigned FW        = 4;
   localparam bit          HAS_FLUSH = (CUT_LAT != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_FLUSH,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t           state;
   logic             start_q;
   logic             rise;
   logic             capture;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] misr;
   logic [CW-1:0]    cnt;
   logic [FW-1:0]    fcnt;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
      return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
   endfunction

   assign rise = start & ~start_q;

   // A response is captured CUT_LAT cycles after its pattern; elapsed cycles = cnt in RUN, N+fcnt in FLUSH
   always_comb begin
      capture = 1'b0;
      if (state == S_RUN)
         capture = (32'(cnt) + 32'd1 > CUT_LAT);
      else if (state == S_FLUSH)
         capture = (N_PATTERNS + 32'(fcnt) + 32'd1 > CUT_LAT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         start_q       <= 1'b1;
         lfsr          <= SEED;
         misr          <= '0;
         cnt           <= '0;
         fcnt          <= '0;
         pattern_out   <= '0;
         pattern_valid <= 1'b0;
         running       <= 1'b0;
         bist_end      <= 1'b0;
         pass          <= 1'b0;
         signature     <= '0;
      end else begin
         start_q  <= start;
         bist_end <= 1'b0;
         if (capture)
            misr <= lfsr_step(misr) ^ cut_resp;

         // Abort from any running state returns to IDLE and clears the verdict
         if (abort && (state == S_INIT || state == S_RUN ||
                       state == S_FLUSH || state == S_COMPARE)) begin
            state         <= S_IDLE;
            running       <= 1'b0;
            pattern_valid <= 1'b0;
            pattern_out   <= '0;
            pass          <= 1'b0;
            signature     <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rise) begin
                     state     <= S_INIT;
                     running   <= 1'b1;
                     lfsr      <= SEED;
                     misr      <= '0;
                     cnt       <= '0;
                     fcnt      <= '0;
                     pass      <= 1'b0;
                     signature <= '0;
                  end
               end
               S_INIT: begin
                  state         <= S_RUN;
                  pattern_out   <= lfsr;
                  pattern_valid <= 1'b1;
                  lfsr          <= lfsr_step(lfsr);
               end
               S_RUN: begin
                  if (cnt == CW'(N_PATTERNS - 1)) begin
                     pattern_out   <= '0;
                     pattern_valid <= 1'b0;
                     state         <= HAS_FLUSH ? S_FLUSH : S_COMPARE;
                  end else begin
                     cnt         <= cnt + CW'(1);
                     pattern_out <= lfsr;
                     lfsr        <= lfsr_step(lfsr);
                  end
               end
               S_FLUSH: begin
                  if (fcnt == FW'(CUT_LAT - 1))
                     state <= S_COMPARE;
                  else
                     fcnt <= fcnt + FW'(1);
               end
               S_COMPARE: begin
                  signature <= misr;
                  pass      <= (misr == GOLDEN);
                  running   <= 1'b0;
                  bist_end  <= 1'b1;
                  state     <= S_DONE;
               end
               S_DONE: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/bist_controller_param.md
Name: bist_controller_param

Overview:
Parametrised successor to the single-sequence BIST controller FSM, launched by the same START rising-edge protocol. Generates WIDTH-bit pseudo-random patterns from a Galois LFSR and applies them to a circuit-under-test (CUT). Compacts CUT responses in a MISR and compares the final signature with a golden value, reporting pass/fail. Sits between the chip test-control logic and one CUT; adds configurable width, pattern count, CUT latency, abort, and signature check.

Parameters:
WIDTH, 8, pattern/response/LFSR/MISR width (>=2)
POLY, 8'hB8, Galois feedback mask, shared by LFSR and MISR
SEED, 8'h01, LFSR load value at INIT (nonzero)
N_PATTERNS, 200, patterns per run (>=1)
CUT_LAT, 0, CUT response latency in clock cycles (0..15)
GOLDEN, 8'h00, expected final MISR signature

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  run request; acted on only on a 0->1 transition
abort  input  1  synchronous abort of a run in progress
cut_resp  input  WIDTH  CUT response
pattern_out  output  WIDTH  current test pattern to CUT
pattern_valid  output  1  high while pattern_out carries a counted pattern
running  output  1  high while a run is in progress
bist_end  output  1  one-cycle pulse at normal run completion
pass  output  1  1 if last completed signature == GOLDEN
signature  output  WIDTH  last completed MISR signature

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; LFSR=SEED; MISR=0; counters 0; start_q=1.
- start_q = registered start. Rise = start & ~start_q. start held at 1 through reset release gives no run; a fresh 0->1 is required.
- LFSR step: lsb=1 -> (x>>1)^POLY, else x>>1. MISR step: next = lfsrstep(misr) ^ cut_resp.
- IDLE: on rise -> INIT.
- INIT (1 cycle): LFSR=SEED, MISR=0, pattern counter=0, pass=0, signature=0; running=1 -> RUN.
- RUN (N_PATTERNS cycles): pattern_out=LFSR, pattern_valid=1, LFSR steps each cycle. Last pattern -> FLUSH if CUT_LAT>0, else COMPARE.
- MISR captures at the edge ending the cycle that is CUT_LAT cycles after each pattern's RUN cycle. Exactly N_PATTERNS captures per run.
- FLUSH (CUT_LAT cycles): pattern_valid=0, pattern_out=0; MISR continues capturing -> COMPARE.
- COMPARE (1 cycle): signature<=MISR; pass<=(MISR==GOLDEN) -> DONE.
- DONE (1 cycle): running=0, bist_end=1 -> IDLE.
- Total running cycles = N_PATTERNS + CUT_LAT + 2. bist_end follows the last running cycle.
- Rise while running (INIT..COMPARE): ignored, no queuing. Rise during DONE: ignored. Rise in IDLE the cycle after DONE: accepted.
- abort=1 in INIT/RUN/FLUSH/COMPARE -> IDLE next edge: running=0, no bist_end, pass=0, signature=0. abort beats start if both occur in the same cycle.
- abort in IDLE/DONE: no effect.
- Reset mid-run: immediate IDLE and reset values; running drops asynchronously.
- Pattern counter width: $clog2(N_PATTERNS+1). No wrap inside a run.
- pass/signature hold their values until the next INIT or reset.

Test Plan:
1. WIDTH=4, POLY=4'hC, SEED=4'h1, N_PATTERNS=4, CUT_LAT=0, GOLDEN=4'h5, cut_resp=~pattern_out; reset release, start 0->1 -> pattern_out 1,C,6,3 with pattern_valid; running 6 cycles; bist_end pulse; signature=4'h5, pass=1.
2. Same run with GOLDEN=4'h0 -> signature=4'h5, pass=0. Second 0->1 start without reset -> identical pattern sequence and result.
3. CUT_LAT=2, cut_resp = ~pattern delayed 2 cycles -> running 8 cycles, signature=4'h5, pass=1.
4. Start rise issued during RUN -> ignored; exactly one bist_end. Start held 1 through reset release -> no run until start 0 then 1.
5. abort during 3rd pattern -> running=0 next cycle, no bist_end, pass=0, signature=0. Next start rise runs normally.
6. reset=0 asserted mid-FLUSH -> all outputs 0 immediately. After release with start already 1 -> stays IDLE.
